// File: rtl/tape_arb_pkg.sv
// tape_arb_pkg: shared state encoding and defaults for the tape/ROM memory arbiter.
package tape_arb_pkg;
    typedef enum logic [2:0] {IDLE, GRANT, ISSUE, WAIT, HOLD, GAP} arb_state_t;
    localparam int DEF_AW = 25;
    localparam int DEF_TMO = 15;
    localparam int DEF_LAT_MAX = 7;
    localparam logic [7:0] ERR_BYTE = 8'hFF;
endpackage

// File: rtl/tape_mem_arb_rr_pick.sv
// rr_pick: combinational round-robin priority encoder, first set req at or after ptr.
module rr_pick #(
    parameter int N = 3,
    parameter int IW = N > 1 ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic          vld,
    output logic [IW-1:0] idx
);
    always_comb begin
        int j;
        vld = 1'b0;
        idx = '0;
        j = 0;
        for (int k = N - 1; k >= 0; k--) begin
            j = int'(ptr) + k;
            j = j >= N ? j - N : j;
            if (req[j]) begin
                vld = 1'b1;
                idx = IW'(j);
            end
        end
    end
endmodule

// File: rtl/tape_mem_arb.sv
// tape_mem_arb: round-robin sharing of the byte-wide tape/ROM read port among N readers.
module tape_mem_arb import tape_arb_pkg::*; #(
    parameter int N = 3,
    parameter int AW = DEF_AW,
    parameter int TMO = DEF_TMO,
    parameter int LAT_MAX = DEF_LAT_MAX
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [N-1:0]  req,
    input  logic [N-1:0]  rd,
    input  logic [N*AW-1:0] addr,
    output logic [N-1:0]  en,
    output logic [7:0]    dout,
    output logic [AW-1:0] mem_addr,
    output logic          mem_rd,
    input  logic [7:0]    mem_din,
    input  logic          mem_ready,
    output logic          err
);
    localparam int IW = N > 1 ? $clog2(N) : 1;
    localparam int TW = $clog2(TMO + 1);
    localparam int LW = $clog2(LAT_MAX + 1);

    arb_state_t state, state_nxt;
    logic [IW-1:0] g, g_nxt, ptr, pick;
    logic pick_vld;
    logic [TW-1:0] tc;
    logic [LW-1:0] lc;
    logic [N-1:0] en_nxt;
    logic mem_rd_nxt;
    logic gnt_rd, gnt_req, tmo_hit, lat_hit;

    rr_pick #(.N(N), .IW(IW)) u_pick (.req(req), .ptr(ptr), .vld(pick_vld), .idx(pick));

    assign gnt_rd = rd[g];
    assign gnt_req = req[g];
    assign tmo_hit = tc == TW'(TMO - 1);
    assign lat_hit = lc == LW'(LAT_MAX - 1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            g <= '0;
            ptr <= '0;
            tc <= '0;
            lc <= '0;
            en <= '0;
            mem_rd <= 1'b0;
            mem_addr <= '0;
            dout <= '0;
            err <= 1'b0;
        end else begin
            state <= state_nxt;
            g <= g_nxt;
            en <= en_nxt;
            mem_rd <= mem_rd_nxt;
            tc <= state == GRANT ? tc + 1'b1 : '0;
            lc <= state == WAIT ? lc + 1'b1 : '0;
            if (state == GRANT && gnt_rd)
                mem_addr <= addr[g*AW +: AW];
            // a read that outruns LAT_MAX still releases the requester, with a marker byte
            if (state == WAIT && mem_ready)
                dout <= mem_din;
            else if (state == WAIT && lat_hit) begin
                dout <= ERR_BYTE;
                err <= 1'b1;
            end
            if (state == HOLD && !gnt_rd)
                ptr <= g == IW'(N - 1) ? '0 : g + 1'b1;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  state_nxt = pick_vld ? GRANT : IDLE;
            GRANT: state_nxt = gnt_rd ? ISSUE : (!gnt_req || tmo_hit) ? GAP : GRANT;
            ISSUE: state_nxt = WAIT;
            WAIT:  state_nxt = (mem_ready || lat_hit) ? HOLD : WAIT;
            HOLD:  state_nxt = gnt_rd ? HOLD : GAP;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        g_nxt = state == IDLE ? pick : g;
        en_nxt = (state_nxt inside {GRANT, ISSUE, WAIT, HOLD}) ? N'(1) << g_nxt : '0;
        mem_rd_nxt = state_nxt == ISSUE;
    end
endmodule

// File: tb/tb_tape_mem_arb.sv
// tb_tape_mem_arb: directed checks of grant rotation, read sequencing, timeouts and reset.
module tb_tape_mem_arb;
    import tape_arb_pkg::*;
    localparam int N = 3;
    localparam int AW = 25;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic [N-1:0] req = '0;
    logic [N-1:0] rd = '0;
    logic [N*AW-1:0] addr = '0;
    logic [N-1:0] en;
    logic [7:0] dout;
    logic [AW-1:0] mem_addr;
    logic mem_rd;
    logic [7:0] mem_din = '0;
    logic mem_ready = 1'b0;
    logic err;
    int checks = 0;
    int errors = 0;
    int rd_pulses = 0;
    int p0;

    always #5 clk = ~clk;
    always @(posedge clk) if (mem_rd) rd_pulses++;

    tape_mem_arb #(.N(N), .AW(AW), .TMO(15), .LAT_MAX(7)) dut (
        .clk(clk), .reset(reset), .req(req), .rd(rd), .addr(addr), .en(en), .dout(dout),
        .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_din(mem_din), .mem_ready(mem_ready), .err(err)
    );

    task automatic step(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        step(2);
        check("rst_en", en, 0);
        check("rst_mem_rd", mem_rd, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_dout", dout, 0);
        check("rst_err", err, 0);
        reset = 1'b0;
        step();
        // single read, memory answers three cycles after the strobe
        p0 = rd_pulses;
        req = 3'b001;
        addr[0*AW +: AW] = 25'h000123;
        step();
        check("t1_en", en, 3'b001);
        rd = 3'b001;
        step();
        check("t1_mem_rd", mem_rd, 1);
        check("t1_mem_addr", mem_addr, 25'h000123);
        step();
        check("t1_mem_rd_low", mem_rd, 0);
        step();
        step();
        mem_ready = 1'b1;
        mem_din = 8'hA5;
        step();
        mem_ready = 1'b0;
        check("t1_dout", dout, 8'hA5);
        check("t1_en_hold", en, 3'b001);
        check("t1_pulses", rd_pulses - p0, 1);
        step();
        check("t1_dout_hold", dout, 8'hA5);
        check("t1_en_hold2", en, 3'b001);
        rd = 3'b000;
        req = 3'b000;
        step();
        check("t1_en_drop", en, 3'b000);
        step();
        // contention from a fresh reset: strict rotation 0,1,2,0,1,2
        reset = 1'b1;
        #1;
        reset = 1'b0;
        req = 3'b111;
        step();
        for (int k = 0; k < 6; k++) begin
            if (k > 0) begin
                step();
                check("t2_idle_en", en, 3'b000);
                step();
            end
            check($sformatf("t2_grant%0d", k), en, 32'd1 << (k % 3));
            rd = en;
            step();
            step();
            mem_ready = 1'b1;
            mem_din = 8'(8'h10 + k);
            step();
            mem_ready = 1'b0;
            check($sformatf("t2_dout%0d", k), dout, 8'h10 + k);
            rd = 3'b000;
            step();
            check($sformatf("t2_gap%0d", k), en, 3'b000);
        end
        // GRANT timeout: rd never arrives, ptr must not advance
        req = 3'b000;
        step();
        req = 3'b010;
        p0 = rd_pulses;
        step();
        check("t3_en", en, 3'b010);
        step(14);
        check("t3_en_before_tmo", en, 3'b010);
        step();
        check("t3_en_tmo", en, 3'b000);
        check("t3_no_mem_rd", rd_pulses - p0, 0);
        req = 3'b111;
        step(2);
        check("t3_next_grant", en, 3'b001);
        req = 3'b000;
        step();
        check("t3_req_drop", en, 3'b000);
        check("t3_no_mem_rd2", rd_pulses - p0, 0);
        step();
        // latency violation on requester 2
        req = 3'b100;
        step();
        check("t4_en", en, 3'b100);
        rd = 3'b100;
        step(2);
        step(6);
        check("t4_dout_pre", dout, 8'h15);
        check("t4_err_pre", err, 0);
        step();
        check("t4_dout_ff", dout, 8'hFF);
        check("t4_err", err, 1);
        mem_ready = 1'b1;
        mem_din = 8'h11;
        step();
        mem_ready = 1'b0;
        check("t4_late_ready", dout, 8'hFF);
        rd = 3'b000;
        req = 3'b000;
        step();
        check("t4_gap", en, 3'b000);
        step();
        req = 3'b001;
        addr[0*AW +: AW] = 25'h0000042;
        step();
        check("t4_good_en", en, 3'b001);
        rd = 3'b001;
        step(2);
        mem_ready = 1'b1;
        mem_din = 8'h3C;
        step();
        mem_ready = 1'b0;
        check("t4_good_dout", dout, 8'h3C);
        check("t4_err_sticky", err, 1);
        rd = 3'b000;
        req = 3'b000;
        step(2);
        // reset two cycles after the read strobe
        req = 3'b010;
        addr[1*AW +: AW] = 25'h00ABCDE;
        step();
        check("t5_en", en, 3'b010);
        rd = 3'b010;
        step();
        check("t5_mem_rd", mem_rd, 1);
        step(2);
        reset = 1'b1;
        #1;
        check("t5_rst_en", en, 0);
        check("t5_rst_mem_rd", mem_rd, 0);
        check("t5_rst_dout", dout, 0);
        check("t5_rst_err", err, 0);
        step();
        reset = 1'b0;
        req = 3'b000;
        rd = 3'b000;
        mem_ready = 1'b1;
        mem_din = 8'h77;
        step();
        mem_ready = 1'b0;
        check("t5_orphan_dout", dout, 0);
        check("t5_orphan_en", en, 0);
        req = 3'b001;
        addr[0*AW +: AW] = 25'h1FFFFFF;
        step();
        check("t5_fresh_en", en, 3'b001);
        rd = 3'b001;
        step();
        check("t5_fresh_addr", mem_addr, 25'h1FFFFFF);
        step();
        mem_ready = 1'b1;
        mem_din = 8'h5A;
        step();
        mem_ready = 1'b0;
        check("t5_fresh_dout", dout, 8'h5A);
        rd = 3'b000;
        req = 3'b000;
        step(2);
        // stray mem_ready in GRANT, addr change after the ISSUE latch
        req = 3'b010;
        addr[1*AW +: AW] = 25'h0000456;
        step();
        check("t6_en", en, 3'b010);
        mem_ready = 1'b1;
        mem_din = 8'hEE;
        step();
        mem_ready = 1'b0;
        check("t6_stray_en", en, 3'b010);
        check("t6_stray_mem_rd", mem_rd, 0);
        check("t6_stray_dout", dout, 8'h5A);
        rd = 3'b010;
        step();
        check("t6_mem_addr", mem_addr, 25'h0000456);
        addr[1*AW +: AW] = 25'h0000789;
        step();
        check("t6_mem_addr_kept", mem_addr, 25'h0000456);
        mem_ready = 1'b1;
        mem_din = 8'h96;
        step();
        mem_ready = 1'b0;
        check("t6_dout", dout, 8'h96);
        check("t6_mem_addr_end", mem_addr, 25'h0000456);
        rd = 3'b000;
        req = 3'b000;
        step();
        check("t6_gap", en, 3'b000);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
